// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage.
//   Holds the PC, issues in-order requests to a variable-latency instruction
//   memory, buffers returned words with their PCs, and presents them to decode
//   through a valid/ready handshake. A redirect from execute restarts fetch
//   at a new PC and squashes everything fetched on the wrong path.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr        request valid / word-aligned byte address
//   imem_ready                memory accepts when imem_req && imem_ready
//   imem_rvalid/imem_rdata    in-order response valid / instruction word
//   redirect/redirect_pc      one-cycle restart pulse / new PC (bits[1:0] ignored)
//   id_valid/id_ready         decode handshake
//   id_instr/id_pc/id_pcplus4 head instruction, its PC, and PC + 4
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int UW = CW + 1;
  // Discarded requests can pile up across back-to-back redirects, so this
  // counter is wider than the in-flight limit of the current stream.
  localparam int DW = CW + 3;

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;              // filled entries from head
  logic [CW-1:0] outstanding_q, outstanding_d;  // allocated, awaiting data
  logic [DW-1:0] discard_q, discard_d;          // wrong-path responses to drop
  logic [31:0]   hold_instr_q, hold_pc_q;
  logic [31:0]   buf_pc_q    [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];

  logic [UW-1:0] used;
  logic [DW-1:0] in_flight;
  logic [AW-1:0] fill_idx, tail_idx;
  logic          accept, pop, fill, drop;
  logic          unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Filled entries are always contiguous from the head, followed by the
  // allocated-but-unfilled ones, so both indices derive from the counters.
  assign fill_idx = head_q + AW'(count_q);
  assign tail_idx = head_q + AW'(count_q + outstanding_q);

  assign id_valid   = (count_q != '0);
  assign id_instr   = id_valid ? buf_instr_q[head_q] : hold_instr_q;
  assign id_pc      = id_valid ? buf_pc_q[head_q]    : hold_pc_q;
  assign id_pcplus4 = id_pc + 32'd4;
  assign imem_addr  = pc_q;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    used      = {1'b0, count_q} + {1'b0, outstanding_q} - UW'(id_valid && id_ready);
    imem_req  = rst && !redirect && (used < UW'(DEPTH));
    accept    = imem_req && imem_ready;
    pop       = id_valid && id_ready && !redirect;
    drop      = imem_rvalid && (discard_q != '0);
    fill      = imem_rvalid && (discard_q == '0) && (outstanding_q != '0);
    in_flight = discard_q + DW'(outstanding_q);

    pc_d          = pc_q;
    head_d        = head_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (redirect) begin
      // Everything still at memory becomes wrong-path; a response arriving
      // this very cycle is one of them and is dropped right now.
      pc_d          = {redirect_pc[31:2], 2'b00};
      count_d       = '0;
      outstanding_d = '0;
      discard_d     = (imem_rvalid && in_flight != '0) ? in_flight - DW'(1) : in_flight;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      head_d        = head_q + AW'(pop);
      count_d       = count_q + CW'(fill) - CW'(pop);
      outstanding_d = outstanding_q + CW'(accept) - CW'(fill);
      discard_d     = discard_q - DW'(drop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      head_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      head_q        <= head_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      // Track the head so the outputs keep their last value once it drains.
      if (id_valid) begin
        hold_instr_q <= buf_instr_q[head_q];
        hold_pc_q    <= buf_pc_q[head_q];
      end
    end
  end

  // NOTE: buffer storage has no reset; an entry is only ever read after the
  // counters say it has been written.
  always_ff @(posedge clk) begin
    if (accept)              buf_pc_q[tail_idx]    <= pc_q;
    if (fill && !redirect)   buf_instr_q[fill_idx] <= imem_rdata;
  end

endmodule
